// File: rtl/box_animator_param_if.sv
// ---------------------------------------------------------------------------
// box_animator_param_if
//
// Purpose:
//    Bundles the colour/enable controls and the VGA plot stream of the box
//    animator so the design and whatever consumes the pixels share one
//    connection.
//
// Signals:
//    iColour   [2:0]    box colour, sampled at the start of each update
//    iEnable            1 = animate, 0 = pause (position frozen)
//    oX        [X_W-1:0] pixel x coordinate
//    oY        [Y_W-1:0] pixel y coordinate
//    oColour   [2:0]    pixel colour
//    oPlot              oX/oY/oColour valid, write the pixel this cycle
//    oNewFrame          one-cycle pulse per frame tick
//    oBusy              animator is drawing, erasing or moving
//
// Modports:
//    master   the animator (drives the o* signals)
//    slave    the pixel consumer / stimulus side (drives the i* signals)
// ---------------------------------------------------------------------------
interface box_animator_param_if #(
   parameter int X_W = 8,
   parameter int Y_W = 7
);

   logic [2:0]     iColour;
   logic           iEnable;
   logic [X_W-1:0] oX;
   logic [Y_W-1:0] oY;
   logic [2:0]     oColour;
   logic           oPlot;
   logic           oNewFrame;
   logic           oBusy;

   modport master (
      input  iColour, iEnable,
      output oX, oY, oColour, oPlot, oNewFrame, oBusy
   );

   modport slave (
      output iColour, iEnable,
      input  oX, oY, oColour, oPlot, oNewFrame, oBusy
   );

endinterface

// File: rtl/box_animator_param.sv
// ---------------------------------------------------------------------------
// box_animator_param
//
// Purpose:
//    Moves a BOX_W x BOX_H box diagonally around an X_SCREEN x Y_SCREEN
//    pixel space, bouncing off all four edges. Every position update is
//    emitted as a pixel stream for a VGA adapter: erase the old box in
//    colour 0, one idle MOVE cycle, then draw the new box in the colour
//    sampled when the update started. Updates are paced by a frame timer
//    and a frames-per-update counter, with a single-entry pending request.
//
// Ports:
//    iClock   system clock, all state on the rising edge
//    iReset   asynchronous, active-high reset
//    bus      box_animator_param_if.master
//             (iColour, iEnable in; oX, oY, oColour, oPlot, oNewFrame,
//              oBusy out)
// ---------------------------------------------------------------------------
module box_animator_param #(
   parameter int X_W               = 8,
   parameter int Y_W               = 7,
   parameter int X_SCREEN          = 160,
   parameter int Y_SCREEN          = 120,
   parameter int BOX_W             = 4,
   parameter int BOX_H             = 4,
   parameter int STEP              = 1,
   parameter int X_START           = 0,
   parameter int Y_START           = 0,
   parameter int CLOCKS_PER_FRAME  = 833333,
   parameter int FRAMES_PER_UPDATE = 15
) (
   input logic                   iClock,
   input logic                   iReset,
   box_animator_param_if.master  bus
);

   localparam int X_MAX = X_SCREEN - BOX_W;
   localparam int Y_MAX = Y_SCREEN - BOX_H;

   // Position arithmetic is one bit wider than the outputs so that
   // pos + STEP can never wrap before it is compared against the limit.
   localparam int PX_W = X_W + 1;
   localparam int PY_W = Y_W + 1;

   localparam int FC_W = (CLOCKS_PER_FRAME > 1)  ? $clog2(CLOCKS_PER_FRAME)  : 1;
   localparam int UC_W = (FRAMES_PER_UPDATE > 1) ? $clog2(FRAMES_PER_UPDATE) : 1;
   localparam int XO_W = (BOX_W > 1) ? $clog2(BOX_W) : 1;
   localparam int YO_W = (BOX_H > 1) ? $clog2(BOX_H) : 1;

   localparam logic [FC_W-1:0] FRAME_LAST = FC_W'(CLOCKS_PER_FRAME - 1);
   localparam logic [UC_W-1:0] UPD_LAST   = UC_W'(FRAMES_PER_UPDATE - 1);
   localparam logic [XO_W-1:0] XOFF_LAST  = XO_W'(BOX_W - 1);
   localparam logic [YO_W-1:0] YOFF_LAST  = YO_W'(BOX_H - 1);
   localparam logic [PX_W-1:0] X_MAX_V    = PX_W'(X_MAX);
   localparam logic [PY_W-1:0] Y_MAX_V    = PY_W'(Y_MAX);
   localparam logic [PX_W-1:0] STEP_X     = PX_W'(STEP);
   localparam logic [PY_W-1:0] STEP_Y     = PY_W'(STEP);
   localparam logic [PX_W-1:0] X_START_V  = PX_W'(X_START);
   localparam logic [PY_W-1:0] Y_START_V  = PY_W'(Y_START);

   typedef enum logic [2:0] {
      INIT_DRAW,
      IDLE,
      ERASE,
      MOVE,
      DRAW
   } stateT;

   stateT           state;
   stateT           stateNext;

   logic [FC_W-1:0] frameCnt;
   logic            newFrame;
   logic [UC_W-1:0] updCnt;
   logic            pending;
   logic            updateReq;

   logic [XO_W-1:0] xOff;
   logic [YO_W-1:0] yOff;
   logic            lastPix;

   logic [PX_W-1:0] posX;
   logic [PY_W-1:0] posY;
   logic            dirRight;
   logic            dirDown;
   logic [2:0]      colourReg;

   logic            plotActive;
   logic            takeUpdate;
   logic            loadColour;
   logic            doMove;
   logic [2:0]      pixColour;

   logic [PX_W-1:0] sumX;
   logic [PY_W-1:0] sumY;

   logic [X_W-1:0]  xReg;
   logic [Y_W-1:0]  yReg;
   logic [2:0]      colourOut;
   logic            plotReg;
   logic            busyReg;

   assign lastPix   = (xOff == XOFF_LAST) && (yOff == YOFF_LAST);
   assign sumX      = posX + PX_W'(xOff);
   assign sumY      = posY + PY_W'(yOff);
   assign updateReq = newFrame && bus.iEnable && (updCnt == UPD_LAST);

   // Free-running frame timer; the tick is registered so oNewFrame is a
   // clean one-cycle pulse that ignores enable and FSM state.
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         frameCnt <= '0;
         newFrame <= 1'b0;
      end else if (frameCnt == FRAME_LAST) begin
         frameCnt <= '0;
         newFrame <= 1'b1;
      end else begin
         frameCnt <= frameCnt + FC_W'(1);
         newFrame <= 1'b0;
      end
   end

   // Frames-per-update counter and the single pending request. A request
   // that lands while one is already pending just leaves it set, and a
   // request arriving in the same cycle IDLE consumes the old one wins, so
   // it is kept as the next pending update.
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         updCnt  <= '0;
         pending <= 1'b0;
      end else begin
         if (newFrame && bus.iEnable) begin
            updCnt <= (updCnt == UPD_LAST) ? '0 : updCnt + UC_W'(1);
         end
         if (updateReq) begin
            pending <= 1'b1;
         end else if (takeUpdate) begin
            pending <= 1'b0;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         state <= INIT_DRAW;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state and per-cycle control. The first INIT_DRAW pixel uses the
   // live iColour because the latched copy is only written on that edge.
   always_comb begin
      stateNext  = state;
      plotActive = 1'b0;
      takeUpdate = 1'b0;
      loadColour = 1'b0;
      doMove     = 1'b0;
      pixColour  = colourReg;
      case (state)
         INIT_DRAW: begin
            plotActive = 1'b1;
            if ((xOff == '0) && (yOff == '0)) begin
               loadColour = 1'b1;
               pixColour  = bus.iColour;
            end
            if (lastPix) begin
               stateNext = IDLE;
            end
         end
         IDLE: begin
            if (pending) begin
               takeUpdate = 1'b1;
               loadColour = 1'b1;
               stateNext  = ERASE;
            end
         end
         ERASE: begin
            plotActive = 1'b1;
            pixColour  = 3'd0;
            if (lastPix) begin
               stateNext = MOVE;
            end
         end
         MOVE: begin
            doMove    = 1'b1;
            stateNext = DRAW;
         end
         DRAW: begin
            plotActive = 1'b1;
            if (lastPix) begin
               stateNext = IDLE;
            end
         end
         default: begin
            stateNext = INIT_DRAW;
         end
      endcase
   end

   // Raster scan of the box: x offset is the inner loop. Both counters
   // return to zero after the last pixel, ready for the next phase.
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         xOff <= '0;
         yOff <= '0;
      end else if (plotActive) begin
         if (xOff == XOFF_LAST) begin
            xOff <= '0;
            yOff <= lastPix ? '0 : yOff + YO_W'(1);
         end else begin
            xOff <= xOff + XO_W'(1);
         end
      end
   end

   // Box position, direction and latched colour. Hitting a limit clamps to
   // it and flips direction; both axes are evaluated in the same MOVE
   // cycle, so a corner reverses both at once.
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         posX      <= X_START_V;
         posY      <= Y_START_V;
         dirRight  <= 1'b1;
         dirDown   <= 1'b1;
         colourReg <= 3'd0;
      end else begin
         if (loadColour) begin
            colourReg <= bus.iColour;
         end
         if (doMove) begin
            if (dirRight) begin
               if (posX + STEP_X >= X_MAX_V) begin
                  posX     <= X_MAX_V;
                  dirRight <= 1'b0;
               end else begin
                  posX <= posX + STEP_X;
               end
            end else begin
               if (posX <= STEP_X) begin
                  posX     <= '0;
                  dirRight <= 1'b1;
               end else begin
                  posX <= posX - STEP_X;
               end
            end
            if (dirDown) begin
               if (posY + STEP_Y >= Y_MAX_V) begin
                  posY    <= Y_MAX_V;
                  dirDown <= 1'b0;
               end else begin
                  posY <= posY + STEP_Y;
               end
            end else begin
               if (posY <= STEP_Y) begin
                  posY    <= '0;
                  dirDown <= 1'b1;
               end else begin
                  posY <= posY - STEP_Y;
               end
            end
         end
      end
   end

   // Registered plot outputs. oBusy is registered alongside them so it is
   // high on exactly the cycles that carry this sequence's pixels and its
   // MOVE gap.
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         xReg      <= '0;
         yReg      <= '0;
         colourOut <= 3'd0;
         plotReg   <= 1'b0;
         busyReg   <= 1'b0;
      end else begin
         plotReg <= plotActive;
         busyReg <= (state != IDLE);
         if (plotActive) begin
            xReg      <= sumX[X_W-1:0];
            yReg      <= sumY[Y_W-1:0];
            colourOut <= pixColour;
         end
      end
   end

   assign bus.oX        = xReg;
   assign bus.oY        = yReg;
   assign bus.oColour   = colourOut;
   assign bus.oPlot     = plotReg;
   assign bus.oNewFrame = newFrame;
   assign bus.oBusy     = busyReg;

endmodule
